// File: rtl/calc_core.sv
// Arithmetic core of the calculator: sequences operand entry, runs add/sub in one
// cycle or an 8-step shift-add multiply, and drives the display value and flags.
module calc_core #(
  parameter int MUL_ITER = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_p,
  input  logic        add_p,
  input  logic        sub_p,
  input  logic        mul_p,
  input  logic        eq_p,
  input  logic [7:0]  sw,
  output logic [15:0] disp_val,
  output logic        disp_neg,
  output logic        ovf,
  output logic [1:0]  op_code,
  output logic        busy,
  output logic        res_valid
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD   = 2'd1;
  localparam logic [1:0] OP_SUB   = 2'd2;
  localparam logic [1:0] OP_MUL   = 2'd3;
  localparam logic [2:0] CNT_LAST = 3'(MUL_ITER - 1);

  state_t      state_r, state_nxt_s;
  logic [15:0] a_r;
  logic [7:0]  b_r;
  logic [15:0] result_r;
  logic        ovf_r;
  logic        neg_r;
  logic [1:0]  op_r;
  logic [7:0]  mplier_r;
  logic [2:0]  cnt_r;
  logic [23:0] prod_r;
  logic        res_valid_r;

  logic        op_hit_s;
  logic [1:0]  op_sel_s;
  logic [16:0] sum_s;
  logic        a_ge_b_s;
  logic [15:0] diff_s;
  logic [23:0] addend_s;
  logic [23:0] prod_nxt_s;
  logic        chain_ok_s;

  // Operator pulse decode: clear and equals outrank every operator key.
  always_comb begin
    op_hit_s = 1'b0;
    op_sel_s = 2'd0;
    if (clr_p || eq_p) begin
      op_hit_s = 1'b0;
    end else if (add_p) begin
      op_hit_s = 1'b1;
      op_sel_s = OP_ADD;
    end else if (sub_p) begin
      op_hit_s = 1'b1;
      op_sel_s = OP_SUB;
    end else if (mul_p) begin
      op_hit_s = 1'b1;
      op_sel_s = OP_MUL;
    end else begin
      op_hit_s = 1'b0;
    end
  end

  // Arithmetic datapath: B is taken straight from sw on the equals edge.
  always_comb begin
    sum_s      = {1'b0, a_r} + {9'h000, sw};
    a_ge_b_s   = (a_r >= {8'h00, sw});
    diff_s     = a_ge_b_s ? (a_r - {8'h00, sw}) : ({8'h00, sw} - a_r);
    addend_s   = mplier_r[0] ? ({8'h00, a_r} << cnt_r) : 24'h000000;
    prod_nxt_s = prod_r + addend_s;
    chain_ok_s = ~ovf_r & ~neg_r;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_A;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (clr_p) begin
      state_nxt_s = S_A;
    end else begin
      case (state_r)
        S_A: begin
          if (op_hit_s) state_nxt_s = S_B;
          else          state_nxt_s = S_A;
        end
        S_B: begin
          if (eq_p && (op_r == OP_MUL))                         state_nxt_s = S_MUL;
          else if (eq_p && ((op_r == OP_ADD) || (op_r == OP_SUB))) state_nxt_s = S_DONE;
          else                                                  state_nxt_s = S_B;
        end
        S_MUL: begin
          if (cnt_r == CNT_LAST) state_nxt_s = S_DONE;
          else                   state_nxt_s = S_MUL;
        end
        S_DONE: begin
          if (op_hit_s && chain_ok_s) state_nxt_s = S_B;
          else                        state_nxt_s = S_DONE;
        end
        default: state_nxt_s = S_A;
      endcase
    end
  end

  // Operand, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= 16'h0000;
      b_r         <= 8'h00;
      result_r    <= 16'h0000;
      ovf_r       <= 1'b0;
      neg_r       <= 1'b0;
      op_r        <= 2'd0;
      mplier_r    <= 8'h00;
      cnt_r       <= 3'd0;
      prod_r      <= 24'h000000;
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= 1'b0;
      if (clr_p) begin
        a_r      <= 16'h0000;
        b_r      <= 8'h00;
        result_r <= 16'h0000;
        ovf_r    <= 1'b0;
        neg_r    <= 1'b0;
        op_r     <= 2'd0;
        mplier_r <= 8'h00;
        cnt_r    <= 3'd0;
        prod_r   <= 24'h000000;
      end else begin
        case (state_r)
          S_A: begin
            if (op_hit_s) begin
              a_r  <= {8'h00, sw};
              op_r <= op_sel_s;
            end
          end
          S_B: begin
            if (eq_p) begin
              b_r <= sw;
              case (op_r)
                OP_ADD: begin
                  result_r    <= sum_s[15:0];
                  ovf_r       <= sum_s[16];
                  neg_r       <= 1'b0;
                  op_r        <= 2'd0;
                  res_valid_r <= 1'b1;
                end
                OP_SUB: begin
                  result_r    <= diff_s;
                  ovf_r       <= 1'b0;
                  neg_r       <= ~a_ge_b_s;
                  op_r        <= 2'd0;
                  res_valid_r <= 1'b1;
                end
                OP_MUL: begin
                  mplier_r <= sw;
                  cnt_r    <= 3'd0;
                  prod_r   <= 24'h000000;
                  ovf_r    <= 1'b0;
                  neg_r    <= 1'b0;
                end
                default: begin
                  op_r <= 2'd0;
                end
              endcase
            end else if (op_hit_s) begin
              op_r <= op_sel_s;
            end
          end
          S_MUL: begin
            prod_r   <= prod_nxt_s;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + 3'd1;
            if (cnt_r == CNT_LAST) begin
              result_r    <= prod_nxt_s[15:0];
              ovf_r       <= |prod_nxt_s[23:16];
              op_r        <= 2'd0;
              res_valid_r <= 1'b1;
            end
          end
          S_DONE: begin
            if (op_hit_s && chain_ok_s) begin
              a_r  <= result_r;
              op_r <= op_sel_s;
            end
          end
          default: begin
            op_r <= 2'd0;
          end
        endcase
      end
    end
  end

  // Output decode: operand entry states show the live switches.
  always_comb begin
    disp_val = 16'h0000;
    case (state_r)
      S_A, S_B: disp_val = {8'h00, sw};
      S_MUL:    disp_val = {8'h00, b_r};
      S_DONE:   disp_val = result_r;
      default:  disp_val = 16'h0000;
    endcase
    busy      = (state_r == S_MUL);
    disp_neg  = neg_r;
    ovf       = ovf_r;
    op_code   = op_r;
    res_valid = res_valid_r;
  end

endmodule

// File: tb/tb_calc_core.sv
// Directed, table-driven bench for calc_core with hand-written multi-cycle sequences.
module tb_calc_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_p, add_p, sub_p, mul_p, eq_p;
  logic [7:0]  sw;
  logic [15:0] disp_val;
  logic        disp_neg, ovf, busy, res_valid;
  logic [1:0]  op_code;

  int n_total = 0;
  int n_pass  = 0;

  calc_core #(.MUL_ITER(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr_p(clr_p), .add_p(add_p), .sub_p(sub_p),
    .mul_p(mul_p), .eq_p(eq_p), .sw(sw), .disp_val(disp_val), .disp_neg(disp_neg),
    .ovf(ovf), .op_code(op_code), .busy(busy), .res_valid(res_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [1:0]  op;
    logic [7:0]  b;
    bit          chain;
    logic [15:0] val;
    bit          neg;
    bit          ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Pulses are raised at a falling edge and dropped at the next one.
  task automatic pulse(input int which);
    case (which)
      0: clr_p = 1'b1;
      1: add_p = 1'b1;
      2: sub_p = 1'b1;
      3: mul_p = 1'b1;
      default: eq_p = 1'b1;
    endcase
    @(negedge clk);
    {clr_p, add_p, sub_p, mul_p, eq_p} = 5'b00000;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  busy_n;
    bit  got;
    if (!v.chain) begin
      pulse(0);
      sw = v.a;
    end
    pulse(int'(v.op));
    sw = v.b;
    pulse(4);
    sw = ~v.b;
    busy_n = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (res_valid) begin
        got = 1'b1;
      end else begin
        if (busy) busy_n++;
        if (busy && k == 0) begin
          chk($sformatf("v%0d_mul_disp_b", idx), int'(disp_val), int'(v.b));
          chk($sformatf("v%0d_mul_opcode", idx), int'(op_code), 3);
        end
        @(negedge clk);
      end
    end
    chk($sformatf("v%0d_res_valid", idx), int'(got), 1);
    chk($sformatf("v%0d_disp_val", idx), int'(disp_val), int'(v.val));
    chk($sformatf("v%0d_disp_neg", idx), int'(disp_neg), int'(v.neg));
    chk($sformatf("v%0d_ovf", idx), int'(ovf), int'(v.ovf));
    chk($sformatf("v%0d_op_code", idx), int'(op_code), 0);
    chk($sformatf("v%0d_busy_cycles", idx), busy_n, (v.op == 2'd3) ? 8 : 0);
    @(negedge clk);
    chk($sformatf("v%0d_rv_one_cycle", idx), int'(res_valid), 0);
  endtask

  initial begin
    bit saw_rv;
    vecs[0]  = '{8'd12,  2'd1, 8'd34,  1'b0, 16'd46,    1'b0, 1'b0};
    vecs[1]  = '{8'd0,   2'd1, 8'd10,  1'b1, 16'd56,    1'b0, 1'b0};
    vecs[2]  = '{8'd20,  2'd2, 8'd50,  1'b0, 16'd30,    1'b1, 1'b0};
    vecs[3]  = '{8'd255, 2'd3, 8'd255, 1'b0, 16'd65025, 1'b0, 1'b0};
    vecs[4]  = '{8'd0,   2'd3, 8'd255, 1'b1, 16'd767,   1'b0, 1'b1};
    vecs[5]  = '{8'd100, 2'd2, 8'd40,  1'b0, 16'd60,    1'b0, 1'b0};
    vecs[6]  = '{8'd5,   2'd2, 8'd5,   1'b0, 16'd0,     1'b0, 1'b0};
    vecs[7]  = '{8'd255, 2'd1, 8'd255, 1'b0, 16'd510,   1'b0, 1'b0};
    vecs[8]  = '{8'd0,   2'd3, 8'd200, 1'b0, 16'd0,     1'b0, 1'b0};
    vecs[9]  = '{8'd0,   2'd1, 8'd7,   1'b1, 16'd7,     1'b0, 1'b0};
    vecs[10] = '{8'd255, 2'd3, 8'd255, 1'b0, 16'd65025, 1'b0, 1'b0};
    vecs[11] = '{8'd0,   2'd1, 8'd255, 1'b1, 16'd65280, 1'b0, 1'b0};
    vecs[12] = '{8'd0,   2'd1, 8'd255, 1'b1, 16'd65535, 1'b0, 1'b0};
    vecs[13] = '{8'd0,   2'd1, 8'd1,   1'b1, 16'd0,     1'b0, 1'b1};

    rst_n = 1'b0;
    {clr_p, add_p, sub_p, mul_p, eq_p} = 5'b00000;
    sw = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_disp_val", int'(disp_val), 0);
    chk("rst_flags", int'({disp_neg, ovf, busy, res_valid}), 0);
    chk("rst_op_code", int'(op_code), 0);
    rst_n = 1'b1;
    @(negedge clk);
    sw = 8'd99;
    #1;
    chk("sa_disp_follows_sw", int'(disp_val), 99);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Negative result blocks chaining: add_p stays in S_DONE.
    run_vec(vecs[2], 100);
    pulse(1);
    chk("neg_chain_op_code", int'(op_code), 0);
    chk("neg_chain_disp", int'(disp_val), 30);

    // Clear on the 4th busy cycle of 200*3.
    pulse(0);
    sw = 8'd200;
    pulse(3);
    sw = 8'd3;
    pulse(4);
    saw_rv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (res_valid) saw_rv = 1'b1;
      @(negedge clk);
    end
    chk("clr_mul_busy_before", int'(busy), 1);
    pulse(0);
    sw = 8'd77;
    #1;
    chk("clr_mul_busy", int'(busy), 0);
    chk("clr_mul_disp_sw", int'(disp_val), 77);
    chk("clr_mul_op_code", int'(op_code), 0);
    chk("clr_mul_flags", int'({disp_neg, ovf}), 0);
    for (int k = 0; k < 12; k++) begin
      if (res_valid) saw_rv = 1'b1;
      @(negedge clk);
    end
    chk("clr_mul_no_res_valid", int'(saw_rv), 0);

    // Clear and equals together in S_B: clear wins.
    sw = 8'd9;
    pulse(1);
    sw = 8'd4;
    clr_p = 1'b1;
    pulse(4);
    chk("clr_eq_res_valid", int'(res_valid), 0);
    chk("clr_eq_op_code", int'(op_code), 0);
    chk("clr_eq_disp_sw", int'(disp_val), 4);
    pulse(4);
    chk("sa_eq_ignored", int'(res_valid), 0);

    // Simultaneous operator pulses: add has priority.
    sw = 8'd5;
    add_p = 1'b1;
    sub_p = 1'b1;
    pulse(3);
    chk("prio_add_op_code", int'(op_code), 1);
    pulse(2);
    chk("replace_op_code", int'(op_code), 2);
    sw = 8'd3;
    pulse(4);
    chk("replace_res_valid", int'(res_valid), 1);
    chk("replace_disp_val", int'(disp_val), 2);
    chk("replace_disp_neg", int'(disp_neg), 0);
    pulse(4);
    chk("done_eq_no_repeat", int'(res_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calc_core.md
Name: calc_core

Overview:
- Arithmetic core of the simple calculator. Sits directly downstream of the button/switch debouncer.
- Consumes one-cycle key pulses (clear, add, subtract, multiply, equals) and the debounced 8-bit switch operand.
- Sequences operand entry, computes the result, and drives the value, sign and flags to the display stage.
- Add and subtract take one cycle. Multiply uses an 8-iteration shift-add datapath. Results can be chained.

Parameters:
- MUL_ITER, 8: shift-add iterations. Equals the operand B width; fixed at 8.

Ports:
- clk, input, 1: debounce-domain clock. All pulse inputs are one cycle wide in this domain.
- rst_n, input, 1: asynchronous, active-low reset.
- clr_p, input, 1: clear pulse (S0).
- add_p, input, 1: add pulse (S1).
- sub_p, input, 1: subtract pulse (S2).
- mul_p, input, 1: multiply pulse (S3).
- eq_p, input, 1: equals pulse (S4).
- sw, input, 8: debounced operand, unsigned.
- disp_val, output, 16: value to display (magnitude).
- disp_neg, output, 1: minus sign for disp_val.
- ovf, output, 1: result exceeded 16 bits.
- op_code, output, 2: pending operator. 0 = none, 1 = add, 2 = sub, 3 = mul.
- busy, output, 1: multiply in progress.
- res_valid, output, 1: one-cycle pulse when a new result is written.

Behaviour:
- Reset (rst_n low, async): state = S_A; internal A = 0, B = 0, result = 0.
  - Outputs: disp_val = 0, disp_neg = 0, ovf = 0, op_code = 0, busy = 0, res_valid = 0.
- Pulse priority when pulses coincide on one edge: clr_p > eq_p > add_p > sub_p > mul_p. Only the highest-priority pulse acts.
- clr_p in any state, including S_MUL: the next edge goes to S_A and clears A, B, result, ovf, disp_neg and op_code. busy drops. No res_valid.
- S_A (enter first operand):
  - disp_val = {8'h00, sw}.
  - An op pulse latches A = {8'h00, sw}, sets op_code, and moves to S_B.
  - eq_p is ignored.
- S_B (enter second operand):
  - disp_val = {8'h00, sw}.
  - A further op pulse only replaces op_code; there is no compute.
  - eq_p latches B = sw, then:
    - Add/sub: result is written on the same edge. Go to S_DONE; res_valid = 1 for the following cycle.
    - Mul: load the multiplier and set the iteration count = 0. Go to S_MUL; busy = 1.
- Add: sum = A + B as a 17-bit value. result = sum[15:0]; ovf = sum[16]; disp_neg = 0.
- Sub:
  - If A >= B: result = A - B, disp_neg = 0.
  - Otherwise: result = B - A (magnitude), disp_neg = 1.
  - ovf = 0.
- S_MUL (shift-add):
  - Each edge: if the current multiplier LSB is 1, add A shifted by the count into a 24-bit product. Then increment the count.
  - On the edge where count == 7:
    - result = product[15:0]; ovf = |product[23:16].
    - Go to S_DONE; busy = 0; res_valid = 1 for the following cycle.
  - Total latency from the eq_p edge to the result-write edge is 8 edges.
  - disp_val holds {8'h00, B} during S_MUL.
  - Non-clear pulses are ignored.
- S_DONE:
  - disp_val = result.
  - An op pulse with ovf = 0 and disp_neg = 0 chains: A = result, set op_code, go to S_B.
  - An op pulse with ovf = 1 or disp_neg = 1 is ignored; only clear leaves this state.
  - eq_p is ignored (no repeat).
- op_code returns to 0 on entering S_DONE and on clear.
- res_valid is high for exactly one cycle per completed operation and is never asserted on clear.
- Changes on sw are not sampled except at op/eq edges. Output disp_val follows sw combinationally via register select in S_A and S_B.

Test Plan:
- Reset, sw = 12, add_p, sw = 34, eq_p -> next cycle: disp_val = 46, disp_neg = 0, ovf = 0, res_valid = 1 for one cycle, op_code = 0.
- sw = 20, sub_p, sw = 50, eq_p -> disp_val = 30, disp_neg = 1. A following add_p is ignored: state stays S_DONE, op_code = 0.
- sw = 255, mul_p, sw = 255, eq_p:
  - busy is high for 8 cycles, then disp_val = 65025, ovf = 0.
  - Chain mul_p, sw = 255, eq_p -> disp_val = 767 (16581375 mod 65536), ovf = 1.
- Chain from 46: add_p, sw = 10, eq_p -> disp_val = 56.
- Start 200*3; assert clr_p on the 4th busy cycle -> next edge: busy = 0, disp_val = sw, op_code = 0, and no res_valid ever pulses.
- In S_B, assert clr_p and eq_p on the same cycle -> clear wins: state S_A, no result written.
- Apply add_p then sub_p in S_B -> op_code = 2. With A = 5, B = 3 -> disp_val = 2.
